switch_output_allocator: RTL

- Round-robin switch allocator for a mesh-NoC router: shares each output port among the input ports that request it.
- Locks the granted input→output path until the tail flit releases it.
- Drives the crossbar routeSelect/outputBusy and sends a one-cycle grant acknowledgement back to each input buffer.
- Replaces fixed-priority allocation, so no input can starve.

---
 rtl/switch_output_allocator_pkg.sv | 27 ++
 rtl/switch_output_allocator_if.sv | 27 ++
 rtl/switch_output_allocator_rr_arbiter.sv | 27 ++
 rtl/switch_output_allocator.sv | 112 +++++++++++
 4 files changed

// File: rtl/switch_output_allocator_pkg.sv
// Shared types and helpers for the round-robin switch output allocator.
// Holds the per-output state encoding and the index-field extractor.
package switch_output_allocator_pkg;

    localparam int STATE_WIDTH = 2;
    localparam int FIELD_MAX = 64;

    typedef enum logic [STATE_WIDTH-1:0] {
        FREE   = 2'd0,
        ACK    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Returns field k (width bits) of a flat bus of index fields.
    function automatic logic [31:0] get_field(
        input logic [FIELD_MAX-1:0] vec,
        input int width,
        input int k
    );
        logic [FIELD_MAX-1:0] sh;
        logic [FIELD_MAX-1:0] mask;
        sh = vec >> (k * width);
        mask = (64'd1 << width) - 64'd1;
        return 32'(sh & mask);
    endfunction

endpackage

// File: rtl/switch_output_allocator_if.sv
// Request/grant bundle between input buffers and the output allocator.
// master: input-buffer side (requests, releases); slave: allocator side.
interface switch_output_allocator_if #(
    parameter int INPUTS = 4,
    parameter int OUTPUTS = 4,
    parameter int REQUEST_WIDTH = 2
);

    logic [INPUTS-1:0]                reqValid;
    logic [INPUTS*REQUEST_WIDTH-1:0]  reqDest;
    logic [INPUTS-1:0]                routeRelieve;
    logic [INPUTS-1:0]                grantAck;
    logic [INPUTS-1:0]                inputHeld;
    logic [OUTPUTS*REQUEST_WIDTH-1:0] routeSelect;
    logic [OUTPUTS-1:0]               outputBusy;

    modport master (
        output reqValid, reqDest, routeRelieve,
        input  grantAck, inputHeld, routeSelect, outputBusy
    );

    modport slave (
        input  reqValid, reqDest, routeRelieve,
        output grantAck, inputHeld, routeSelect, outputBusy
    );

endinterface

// File: rtl/switch_output_allocator_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
// Ports: req (request vector), ptr (start index), gnt_idx, gnt_valid.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    always_comb begin
        int idx;
        idx = 0;
        gnt_valid = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx = W'(idx);
            end
        end
    end

endmodule

// File: rtl/switch_output_allocator.sv
// Round-robin switch allocator: per-output FREE/ACK/LOCKED path locking.
// Ports: clk, rst (async, active-high), bus (slave side of the bundle).
module switch_output_allocator
    import switch_output_allocator_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int OUTPUTS = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input logic                     clk,
    input logic                     rst,
    switch_output_allocator_if.slave bus
);

    localparam int RW = REQUEST_WIDTH;

    state_t             state [OUTPUTS];
    logic [RW-1:0]      owner [OUTPUTS];
    logic [RW-1:0]      ptr   [OUTPUTS];
    logic [RW-1:0]      sel   [OUTPUTS];
    logic [OUTPUTS-1:0] busy;

    logic [RW-1:0]      dest  [INPUTS];
    logic [INPUTS-1:0]  cand  [OUTPUTS];
    logic [RW-1:0]      win   [OUTPUTS];
    logic [OUTPUTS-1:0] win_valid;
    logic [INPUTS-1:0]  busy_in;
    logic [INPUTS-1:0]  ack_vec;
    logic [INPUTS-1:0]  held_vec;

    always_comb begin
        for (int j = 0; j < INPUTS; j++) begin
            dest[j] = RW'(get_field(64'(bus.reqDest), RW, j));
        end
    end

    // Owner decode from registered state only; no input-to-output path.
    always_comb begin
        busy_in = '0;
        ack_vec = '0;
        held_vec = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (state[o] != FREE) busy_in[owner[o]] = 1'b1;
            if (state[o] == ACK) ack_vec[owner[o]] = 1'b1;
            if (state[o] == LOCKED) held_vec[owner[o]] = 1'b1;
        end
    end

    // Out-of-range destinations never equal any o, so they drop out here.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            for (int j = 0; j < INPUTS; j++) begin
                cand[o][j] = bus.reqValid[j]
                           && (int'(dest[j]) == o)
                           && !busy_in[j];
            end
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
        rr_arbiter #(
            .N(INPUTS),
            .W(RW)
        ) u_arb (
            .req      (cand[o]),
            .ptr      (ptr[o]),
            .gnt_idx  (win[o]),
            .gnt_valid(win_valid[o])
        );

        assign bus.routeSelect[o*RW +: RW] = sel[o];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int o = 0; o < OUTPUTS; o++) begin
                state[o] <= FREE;
                owner[o] <= '0;
                ptr[o]   <= '0;
                sel[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < OUTPUTS; o++) begin
                unique case (state[o])
                    FREE: begin
                        if (win_valid[o]) begin
                            owner[o] <= win[o];
                            sel[o]   <= win[o];
                            busy[o]  <= 1'b1;
                            state[o] <= ACK;
                        end
                    end
                    ACK: state[o] <= LOCKED;
                    LOCKED: begin
                        if (bus.routeRelieve[owner[o]]) begin
                            state[o] <= FREE;
                            busy[o]  <= 1'b0;
                            ptr[o]   <= RW'((int'(owner[o]) + 1) % INPUTS);
                        end
                    end
                    default: state[o] <= FREE;
                endcase
            end
        end
    end

    assign bus.grantAck   = ack_vec;
    assign bus.inputHeld  = held_vec;
    assign bus.outputBusy = busy;

endmodule
